// File: rtl/uart_tx.sv
// UART transmitter: one-byte holding register feeding a start/8-data/even-parity/stop framer.
// States: IDLE line high | START start bit | DATA 8 data bits LSB first | PARITY even parity | STOP stop bit
module uart_tx #(
    parameter int unsigned CLK_TX     = 50000,
    parameter int unsigned BAUDRATE   = 10000,
    parameter int unsigned BIT_CYCLES = CLK_TX / BAUDRATE,
    parameter logic [31:0] TX_ADDRESS = 32'h0040_0104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic [31:0] address,
    input  logic        we,
    output logic        data_tx,
    output logic        ready,
    output logic        busy
);

    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          tx_q, tx_d;
    logic          wr_accept;
    logic          load;
    logic          baud_last;

    assign wr_accept = we && (address == TX_ADDRESS) && !hold_full_q;
    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_d        = tx_q;
        load        = 1'b0;

        if (state_q != IDLE) begin
            baud_d = baud_last ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = START;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d   = PARITY;
                        tx_d      = parity_q;
                        bit_idx_d = '0;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (baud_last) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                // A queued byte starts immediately after the stop bit, no idle gap.
                if (baud_last) begin
                    if (hold_full_q) begin
                        load    = 1'b1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // load needs a full holding register and wr_accept an empty one, so they never coincide.
        if (load) begin
            shift_d     = hold_q;
            parity_d    = ^hold_q;
            hold_full_d = 1'b0;
            bit_idx_d   = '0;
        end else if (wr_accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
        end
    end

    assign data_tx = tx_q;
    assign ready   = ~hold_full_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: cycle-level frame model, line decoder and bit-width sweeps.
module tb_uart_tx;

    localparam logic [31:0] ADDR = 32'h0040_0104;
    localparam int B = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   = 1'b1;
    logic [7:0]  din   = 8'h00;
    logic [31:0] addr  = 32'h0;
    logic        we_m  = 1'b0;
    logic        we_2  = 1'b0;
    logic        we_16 = 1'b0;
    logic tx_m, rdy_m, busy_m, tx_2, rdy_2, busy_2, tx_16, rdy_16, busy_16;

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx dut (.clk(clk), .reset(rst), .data_in(din), .address(addr), .we(we_m),
                 .data_tx(tx_m), .ready(rdy_m), .busy(busy_m));
    uart_tx #(.BIT_CYCLES(2)) u_b2 (.clk(clk), .reset(rst), .data_in(din), .address(addr), .we(we_2),
                 .data_tx(tx_2), .ready(rdy_2), .busy(busy_2));
    uart_tx #(.BIT_CYCLES(16)) u_b16 (.clk(clk), .reset(rst), .data_in(din), .address(addr), .we(we_16),
                 .data_tx(tx_16), .ready(rdy_16), .busy(busy_16));

    int   sel_r = 0;
    logic sw_tx, sw_busy, sw_rdy;
    assign sw_tx   = (sel_r == 0) ? tx_m   : (sel_r == 1) ? tx_2   : tx_16;
    assign sw_busy = (sel_r == 0) ? busy_m : (sel_r == 1) ? busy_2 : busy_16;
    assign sw_rdy  = (sel_r == 0) ? rdy_m  : (sel_r == 1) ? rdy_2  : rdy_16;

    // Reference model of the default instance: frame position counter plus holding slot.
    bit          m_act  = 1'b0;
    int          m_pos  = 0;
    bit          m_full = 1'b0;
    logic [7:0]  m_hold = 8'h00;
    logic [10:0] m_frame = '1;
    logic [7:0]  m_sent[$];

    always @(posedge clk) begin : model
        bit act, full, acc;
        int pos;
        logic [7:0] hb;
        logic [10:0] fb;
        if (rst) begin
            m_act  <= 1'b0;
            m_pos  <= 0;
            m_full <= 1'b0;
        end else begin
            act = m_act; pos = m_pos; full = m_full; hb = m_hold; fb = m_frame;
            acc = we_m && (addr == ADDR) && !full;
            if (act) begin
                pos = pos + 1;
                if (pos == 11 * B) act = 1'b0;
            end
            if (!act && full) begin
                act = 1'b1; pos = 0; full = 1'b0;
                fb = {1'b1, ^hb, hb, 1'b0};
                m_sent.push_back(hb);
            end
            if (acc) begin
                full = 1'b1; hb = din;
            end
            m_act <= act; m_pos <= pos; m_full <= full; m_hold <= hb; m_frame <= fb;
        end
    end

    // Line decoder on the default instance: samples mid-bit, records {stop, parity, byte}.
    bit          d_on  = 1'b0;
    int          d_cnt = 0;
    logic [10:0] d_bits = '0;
    logic [9:0]  rx_q[$];

    always @(negedge clk) begin
        if (rst) begin
            d_on <= 1'b0;
        end else if (!d_on) begin
            if (tx_m === 1'b0) begin
                d_on  <= 1'b1;
                d_cnt <= 1;
            end
        end else begin
            d_cnt <= d_cnt + 1;
            if (d_cnt == 10 * B + B / 2) begin
                d_on <= 1'b0;
                rx_q.push_back({tx_m, d_bits[9:1]});
            end else if (d_cnt % B == B / 2) begin
                d_bits[d_cnt / B] <= tx_m;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        chk("model_tx", 32'(tx_m), 32'(m_act ? m_frame[m_pos / B] : 1'b1));
        chk("model_busy", 32'(busy_m), 32'(m_act));
        chk("model_ready", 32'(rdy_m), 32'(!m_full));
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] b);
        logic [9:0] got;
        if (rx_q.size() == 0) got = 'x;
        else got = rx_q.pop_front();
        chk(tag, 32'(got), 32'({1'b1, ^b, b}));
    endtask

    task automatic run_frame(input int s, input int b, input logic [7:0] d);
        logic [10:0] fb;
        logic        smp[176];
        int          nb, bad;
        fb = {1'b1, ^d, d, 1'b0};
        sel_r = s; addr = ADDR; din = d;
        if (s == 0) we_m = 1'b1; else if (s == 1) we_2 = 1'b1; else we_16 = 1'b1;
        cycle();
        we_m = 1'b0; we_2 = 1'b0; we_16 = 1'b0;
        chk("frame_line_before_start", 32'(sw_tx), 32'd1);
        nb = 0;
        for (int c = 0; c < 11 * b; c++) begin
            cycle();
            smp[c] = sw_tx;
            if (sw_busy === 1'b1) nb++;
        end
        for (int k = 0; k < 11; k++) begin
            bad = 0;
            for (int c = k * b; c < (k + 1) * b; c++) if (smp[c] !== fb[k]) bad++;
            chk($sformatf("frame_bit%0d_width%0d", k, b), 32'(bad), 32'd0);
        end
        chk("frame_busy_cycles", 32'(nb), 32'(11 * b));
        cycle();
        chk("frame_end_tx", 32'(sw_tx), 32'd1);
        chk("frame_end_busy", 32'(sw_busy), 32'd0);
        chk("frame_end_ready", 32'(sw_rdy), 32'd1);
    endtask

    initial begin
        int nb, n, gap;

        rst = 1'b1;
        cycle();
        cycle();
        chk("reset_tx", 32'(tx_m), 32'd1);
        chk("reset_ready", 32'(rdy_m), 32'd1);
        chk("reset_busy", 32'(busy_m), 32'd0);
        rst = 1'b0;
        cycle();

        run_frame(0, B, 8'hA5);
        expect_rx("rx_a5", 8'hA5);
        run_frame(0, B, 8'h01);
        expect_rx("rx_01", 8'h01);
        run_frame(0, B, 8'h00);
        expect_rx("rx_00", 8'h00);

        for (int t = 0; t < 2; t++) begin
            din = 8'h3C;
            addr = (t == 0) ? 32'h0040_0100 : ADDR;
            we_m = (t == 0);
            cycle();
            we_m = 1'b0;
            for (int i = 0; i < 60; i++) begin
                cycle();
                chk("ignored_tx", 32'(tx_m), 32'd1);
                chk("ignored_busy", 32'(busy_m), 32'd0);
                chk("ignored_ready", 32'(rdy_m), 32'd1);
            end
        end
        chk("ignored_rx_empty", 32'(rx_q.size()), 32'd0);

        addr = ADDR; din = 8'h3C; we_m = 1'b1;
        cycle();
        we_m = 1'b0;
        nb = 0; n = 0;
        while (n < 300) begin
            cycle();
            n++;
            if (busy_m === 1'b1) nb++;
            else if (nb > 0) break;
            if (n == 10) begin
                din = 8'hC3; we_m = 1'b1;
            end else if (n == 20) begin
                chk("b2b_ready_low", 32'(rdy_m), 32'd0);
                din = 8'hFF; we_m = 1'b1;
            end else begin
                we_m = 1'b0;
            end
        end
        we_m = 1'b0;
        chk("b2b_contiguous_busy", 32'(nb), 32'd110);
        repeat (5) cycle();
        expect_rx("rx_b2b_3c", 8'h3C);
        expect_rx("rx_b2b_c3", 8'hC3);
        chk("b2b_no_ff", 32'(rx_q.size()), 32'd0);

        din = 8'hAA; we_m = 1'b1;
        cycle();
        for (int i = 1; i <= 22; i++) begin
            if (i == 5) begin
                din = 8'h55; we_m = 1'b1;
            end else begin
                we_m = 1'b0;
            end
            cycle();
        end
        we_m = 1'b0;
        chk("rst_mid_queued", 32'(rdy_m), 32'd0);
        chk("rst_mid_busy", 32'(busy_m), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_mid_tx", 32'(tx_m), 32'd1);
        chk("rst_mid_busy_after", 32'(busy_m), 32'd0);
        chk("rst_mid_ready_after", 32'(rdy_m), 32'd1);
        nb = 0;
        for (int i = 0; i < 150; i++) begin
            cycle();
            if (busy_m !== 1'b0) nb++;
        end
        chk("rst_no_further_frame", 32'(nb), 32'd0);
        chk("rst_rx_empty", 32'(rx_q.size()), 32'd0);

        run_frame(1, 2, 8'($urandom));
        run_frame(2, 16, 8'($urandom));
        sel_r = 0;

        rx_q.delete();
        m_sent.delete();
        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 70);
            repeat (gap) cycle();
            din  = 8'($urandom);
            addr = ($urandom_range(0, 3) == 0) ? (ADDR ^ (32'h1 << $urandom_range(0, 31))) : ADDR;
            we_m = ($urandom_range(0, 7) != 0);
            cycle();
            we_m = 1'b0;
        end
        addr = ADDR;
        for (int i = 0; i < 200 && (m_act || m_full); i++) cycle();
        chk("rand_drained", 32'(busy_m || !rdy_m), 32'd0);
        repeat (5) cycle();
        chk("rand_frame_count", 32'(rx_q.size()), 32'(m_sent.size()));
        while (m_sent.size() > 0) expect_rx("rand_byte", m_sent.pop_front());

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial transmitter for the UART link, and the sending counterpart of uart_rx. A memory-mapped write to TX_ADDRESS loads one byte into a single-entry holding register. The byte is then sent on data_tx as: start bit (0), 8 data bits LSB first, even parity bit (^data), stop bit (1). This is the same frame format uart_rx checks. The holding register lets software queue the next byte while the current frame is on the line.

Parameters:
clk_tx, 50000, system clock frequency in Hz
Baudrate, 10000, line bit rate in bits/s
BIT_CYCLES, clk_tx/Baudrate (=5), clock cycles per serial bit; must be >=2
TX_ADDRESS, 'h400104, 32-bit address that selects this block

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
data_in  input  8  byte to transmit
address  input  32  write address
we  input  1  write enable
data_tx  output  1  serial line; idles high; registered
ready  output  1  1 when the holding register is empty and a write will be accepted
busy  output  1  1 while a frame (start through stop) is on the line

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on posedge clk.
- Reset values: data_tx=1, ready=1, busy=0. State=IDLE, baud counter=0, bit index=0, holding register empty.
- Reset during a frame: data_tx=1 on the edge that samples reset. The frame is abandoned and any queued byte is discarded.
- Write acceptance: a write is accepted at an edge when we=1, address==TX_ADDRESS (full 32-bit compare) and ready=1. The accepted byte goes into the holding register and ready=0 after that edge.
- Ignored writes: address mismatch, or ready=0. No state changes and the byte is dropped.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: data_tx=1, busy=0. If the holding register is full, the next edge does all of the following:
  - goes to START, with data_tx=0 and busy=1;
  - copies the holding register into the shift register and records parity = ^byte;
  - empties the holding register, so ready=1.
- Latency: a write accepted at edge E while idle gives the falling start edge on data_tx at E+1.
- Bit timing: every bit is held for exactly BIT_CYCLES clocks. The baud counter counts 0..BIT_CYCLES-1 and wraps to 0 on each bit advance.
- START: after BIT_CYCLES clocks go to DATA and drive bit 0.
- DATA: drive shift[0] and shift right on each bit advance. The bit index counts 0..7; after bit 7 go to PARITY.
- PARITY: drive the stored parity bit, then go to STOP.
- STOP: drive data_tx=1. On the last cycle of STOP:
  - holding register full: go directly to START. The next start bit follows the stop bit with no idle gap, and the holding register empties.
  - otherwise: go to IDLE.
- Frame length: 11*BIT_CYCLES clocks from the start edge to the end of the stop bit (55 clocks with defaults).
- busy: 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Writes during a frame: a write may be accepted while busy=1 if ready=1. It is queued and does not disturb the frame in progress.
- Simultaneous write and holding-to-shift transfer: the write is ignored, because ready=0 at that edge. ready rises only after the transfer edge.
- No other outputs: no underflow, overflow or error indication.

Test Plan:
1. Reset, then write 0xA5 to 'h400104 → data_tx falls 1 clock after the accepting edge. The line carries 0,1,0,1,0,0,1,0,1, parity 0, stop 1, each bit held 5 clocks. busy is 1 for exactly 55 clocks, then data_tx=1 and busy=0.
2. Write 0x01 → parity bit=1. Write 0x00 → parity bit=0 and data bits all 0. Check both against an even-parity reference.
3. Write 0x3C to 'h400100, and separately write 0x3C with we=0 → data_tx stays 1, busy=0, ready=1 throughout.
4. Back-to-back:
   - Write 0x3C, then write 0xC3 during the 0x3C frame → ready=0 until 0xC3 moves to the shift register.
   - 0xC3's start bit begins on the clock right after 0x3C's stop bit ends (110 contiguous clocks of framing).
   - A third write (0xFF) issued while ready=0 never appears on the line.
5. Reset asserted for 1 clock during DATA bit 3, with a byte queued → data_tx=1, busy=0, ready=1 after that edge. No further frame is sent.
6. Parameter sweep BIT_CYCLES=2 and BIT_CYCLES=16 → every bit width equals BIT_CYCLES. Frame length is 22 and 176 clocks respectively.
